seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

- Drives a two-digit, multiplexed, common-anode seven-segment display from the state-sequencer outputs.
- Digit 0 shows the student ID digit; digit 1 shows the current state number.
- Inputs are captured once per scan frame so a digit never changes partway through its slot.
- Segment and anode outputs are registered, active-low, and blanked at the start of every slot to suppress ghosting.

## Interface
- DIV, default 50000: clock cycles per digit slot; legal when 2 ≤ DIV ≤ 2^20.
- BLANK, default 16: cycles at the start of each slot during which both anodes are off; legal when 1 ≤ BLANK < DIV.
- clk  input  1  system clock. This is the block's only clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- student_id  input  4  digit value shown on digit 0.
- current_state  input  4  state number shown on digit 1.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- an  output  2  anode enables, active-low; an[0] is digit 0 and an[1] is digit 1.

## Operation
- Internal state:
  - cnt: slot counter, width ceil(log2(DIV)).
  - sel: slot select, 0 for digit 0 and 1 for digit 1.
  - hold_id, hold_state: 4-bit capture registers.
- Reset, at an edge with reset=1: cnt=0, sel=0, hold_id=0, hold_state=0, seg=7'h7F, an=2'b11.
- Reset takes priority at any point, including mid-slot. The next edge forces all reset values.
- Each edge with reset=0. All conditions use the values present before the edge.
  - cnt: if cnt==DIV-1, then cnt<=0 and sel<=~sel; otherwise cnt<=cnt+1.
  - Capture: if cnt==0 and sel==0, then hold_id<=student_id and hold_state<=current_state. No capture happens on any other edge.
  - Blanking: if cnt<BLANK, then an<=2'b11 and seg<=7'h7F.
  - Display: otherwise an<=(sel ? 2'b01 : 2'b10) and seg<=decode(sel ? hold_state : hold_id).
- Only one anode is ever low. The value an=2'b00 must never occur.
- decode, full hex, active-low, shown as 4-bit value followed by the seg code:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Input values 10–15 are legal and are shown as hex digits. For example, the sequencer's fault code 4'b1110 shows as "E".
- A change to student_id or current_state is ignored until the next frame-start capture edge.

## Timing
- Frame: 2·DIV cycles, made of slot 0 (digit 0) then slot 1 (digit 1).
- Edges are numbered 1, 2, … from the first edge with reset=0 after reset.
- Edge 1: capture occurs; an=11.
- Edges 1..BLANK: an=11, seg=7F.
- Edges BLANK+1..DIV: an=10, seg=decode(hold_id).
- Edges DIV+1..DIV+BLANK: an=11, seg=7F.
- Edges DIV+BLANK+1..2·DIV: an=01, seg=decode(hold_state).
- Edge 2·DIV+1: next capture; the pattern repeats with period 2·DIV.
- Latency from input capture to display: BLANK edges after the capture edge.
- Worst case from an input change to display: 2·DIV+BLANK cycles.
- Counter wrap: at cnt==DIV-1, cnt returns to 0 and sel toggles on the same edge. There are no missing or extra cycles.

## Test plan
- Reset: with DIV=8 and BLANK=2, hold reset=1 for 3 edges → seg=7F, an=11 after each edge. Release reset → an=11 after edges 1–2 and an=10 after edge 3.
- Normal scan: with DIV=8, BLANK=2, student_id=5, current_state=0 → after edges 3–8, an=10 and seg=12. After edges 9–10, an=11. After edges 11–16, an=01 and seg=40. Period is 16.
- Capture isolation: change student_id from 5 to 9 at edge 5 → seg stays 12 through edge 8 and edges 17–18 blank. seg=10 from edge 19.
- Full decode: with current_state stepped through 0–F one per frame → digit 1 shows the seg code from each decode entry in order. Confirm the fault code 4'b1110 gives 06.
- Mid-slot reset: assert reset at edge 12, during slot 1 → seg=7F and an=11 at the next edge. After release, the timeline restarts from edge 1 and a new capture occurs.
- Anode invariant: random inputs over 10,000 cycles with DIV=5 and BLANK=1 → an is never 00, and an=11 on every blanking edge.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: two-digit multiplexed common-anode 7-seg scanner with per-frame input capture
module seg_scan_driver #(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] student_id,
    input  logic [3:0] current_state,
    output logic [6:0] seg,
    output logic [1:0] an
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    logic          sel;
    logic          last;
    logic          blank;
    logic [3:0]    hold_id;
    logic [3:0]    hold_state;
    logic [3:0]    digit;
    logic [6:0]    code;
    assign last  = cnt == CW'(DIV - 1);
    assign blank = cnt < CW'(BLANK);
    assign digit = sel ? hold_state : hold_id;
    always_comb begin
        code = 7'h7F;
        case (digit)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            4'hF: code = 7'h0E;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            sel        <= 1'b0;
            hold_id    <= '0;
            hold_state <= '0;
            seg        <= 7'h7F;
            an         <= 2'b11;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            sel <= sel ^ last;
            // inputs are sampled only at frame start so neither digit tears mid-slot
            if (cnt == '0 && !sel) begin
                hold_id    <= student_id;
                hold_state <= current_state;
            end
            an  <= blank ? 2'b11 : (sel ? 2'b01 : 2'b10);
            seg <= blank ? 7'h7F : code;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of the scan timeline, capture, decode, reset and anode invariant
module tb_seg_scan_driver;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] student_id = 4'h0;
    logic [3:0] current_state = 4'h0;
    logic [6:0] seg, seg2;
    logic [1:0] an, an2;
    int checks = 0;
    int errs = 0;
    int e = 0;
    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg_scan_driver #(.DIV(8), .BLANK(2)) dut (
        .clk(clk), .reset(reset), .student_id(student_id),
        .current_state(current_state), .seg(seg), .an(an)
    );
    seg_scan_driver #(.DIV(5), .BLANK(1)) dut2 (
        .clk(clk), .reset(reset), .student_id(student_id),
        .current_state(current_state), .seg(seg2), .an(an2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        e = 0;
    endtask

    function automatic logic [1:0] x_an(int k);
        int p = (k - 1) % 16;
        return p < 2 ? 2'b11 : p < 8 ? 2'b10 : p < 10 ? 2'b11 : 2'b01;
    endfunction

    function automatic logic [6:0] x_seg(int k, logic [3:0] id, logic [3:0] st);
        logic [1:0] a = x_an(k);
        return a == 2'b11 ? 7'h7F : a == 2'b10 ? dec[id] : dec[st];
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++;
            if (seg !== 7'h7F || an !== 2'b11) begin
                errs++;
                $display("FAIL reset_hold edge %0d: seg=%h an=%b, want seg=7f an=11", i, seg, an);
            end
        end
        reset = 1'b0;
        e = 0;
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++;
            if (an !== (i < 3 ? 2'b11 : 2'b10)) begin
                errs++;
                $display("FAIL reset_release edge %0d: an=%b, want %b", e, an, i < 3 ? 2'b11 : 2'b10);
            end
        end
    endtask

    task automatic test_normal_scan;
        student_id = 4'h5;
        current_state = 4'h0;
        do_reset;
        for (int i = 1; i <= 32; i++) begin
            tick;
            checks++;
            if (an !== x_an(e) || seg !== x_seg(e, 4'h5, 4'h0)) begin
                errs++;
                $display("FAIL normal_scan edge %0d: seg=%h an=%b, want seg=%h an=%b",
                         e, seg, an, x_seg(e, 4'h5, 4'h0), x_an(e));
            end
        end
    endtask

    task automatic test_capture_isolation;
        student_id = 4'h5;
        current_state = 4'h0;
        do_reset;
        repeat (4) tick;
        student_id = 4'h9;
        for (int i = 5; i <= 24; i++) begin
            tick;
            if (e <= 8 || e >= 17) begin
                checks++;
                if (an !== x_an(e) || seg !== x_seg(e, e <= 16 ? 4'h5 : 4'h9, 4'h0)) begin
                    errs++;
                    $display("FAIL capture_isolation edge %0d: seg=%h an=%b, want seg=%h an=%b",
                             e, seg, an, x_seg(e, e <= 16 ? 4'h5 : 4'h9, 4'h0), x_an(e));
                end
            end
        end
    endtask

    task automatic test_full_decode;
        current_state = 4'h0;
        student_id = 4'hF;
        do_reset;
        for (int v = 0; v < 16; v++) begin
            current_state = 4'(v);
            student_id = 4'(15 - v);
            for (int i = 1; i <= 16; i++) begin
                tick;
                if (i == 3) begin
                    checks++;
                    if (an !== 2'b10 || seg !== dec[15 - v]) begin
                        errs++;
                        $display("FAIL decode_digit0 value %h: seg=%h an=%b, want seg=%h an=10",
                                 15 - v, seg, an, dec[15 - v]);
                    end
                end
                if (i == 11) begin
                    checks++;
                    if (an !== 2'b01 || seg !== dec[v]) begin
                        errs++;
                        $display("FAIL decode_digit1 value %h: seg=%h an=%b, want seg=%h an=01",
                                 v, seg, an, dec[v]);
                    end
                end
            end
        end
        current_state = 4'b1110;
        repeat (11) tick;
        checks++;
        if (seg !== 7'h06) begin
            errs++;
            $display("FAIL fault_code_E: seg=%h, want 06", seg);
        end
    endtask

    task automatic test_mid_slot_reset;
        student_id = 4'h3;
        current_state = 4'h7;
        do_reset;
        repeat (11) tick;
        checks++;
        if (an !== 2'b01 || seg !== 7'h78) begin
            errs++;
            $display("FAIL pre_reset_slot1: seg=%h an=%b, want seg=78 an=01", seg, an);
        end
        reset = 1'b1;
        tick;
        checks++;
        if (seg !== 7'h7F || an !== 2'b11) begin
            errs++;
            $display("FAIL mid_slot_reset: seg=%h an=%b, want seg=7f an=11", seg, an);
        end
        student_id = 4'h8;
        current_state = 4'h2;
        reset = 1'b0;
        e = 0;
        for (int i = 1; i <= 16; i++) begin
            tick;
            checks++;
            if (an !== x_an(e) || seg !== x_seg(e, 4'h8, 4'h2)) begin
                errs++;
                $display("FAIL restart edge %0d: seg=%h an=%b, want seg=%h an=%b",
                         e, seg, an, x_seg(e, 4'h8, 4'h2), x_an(e));
            end
        end
    endtask

    task automatic test_anode_invariant;
        logic [3:0] mid, mst;
        logic [6:0] xs;
        logic [1:0] xa;
        int p;
        mid = 4'h0;
        mst = 4'h0;
        do_reset;
        for (int k = 1; k <= 10000; k++) begin
            if ((k - 1) % 10 == 0) begin
                mid = student_id;
                mst = current_state;
            end
            tick;
            p = (k - 1) % 10;
            xa = (p == 0 || p == 5) ? 2'b11 : p < 5 ? 2'b10 : 2'b01;
            xs = xa == 2'b11 ? 7'h7F : xa == 2'b10 ? dec[mid] : dec[mst];
            checks++;
            if (an2 === 2'b00 || an2 !== xa || seg2 !== xs) begin
                errs++;
                if (errs < 20)
                    $display("FAIL anode_invariant edge %0d: seg=%h an=%b, want seg=%h an=%b",
                             k, seg2, an2, xs, xa);
            end
            student_id = 4'($urandom_range(0, 15));
            current_state = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        test_reset;
        test_normal_scan;
        test_capture_isolation;
        test_full_decode;
        test_mid_slot_reset;
        test_anode_invariant;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
